// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bit-serial address/data bus and its slaves.
//   - Frame geometry: 14-bit address (2-bit device select + 12-bit offset),
//     8-bit data, both sent MSB first.
//   - Slave FSM state encoding.
//   - Bit-counter landmarks used by the slave deserialiser / serialiser.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int ADDR_BITS    = 14;
    localparam int DATA_BITS    = 8;
    localparam int DEV_SEL_BITS = 2;

    // Address field split: [13:12] device select, [11:0] local byte offset.
    localparam int OFFSET_BITS = ADDR_BITS - DEV_SEL_BITS;
    localparam int SEL_MSB     = ADDR_BITS - 1;
    localparam int SEL_LSB     = OFFSET_BITS;

    // One counter serves both the address phase (0..13) and the read-out
    // phase (0..7).
    localparam int CNT_BITS = 4;
    localparam logic [CNT_BITS-1:0] ADDR_LAST_CNT  = 4'd13;
    // The write datum rides on the last 8 address cycles.
    localparam logic [CNT_BITS-1:0] DATA_FIRST_CNT = 4'd6;
    localparam logic [CNT_BITS-1:0] TX_LAST_CNT    = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WCOMMIT = 3'd2,
        S_RFETCH  = 3'd3,
        S_RSTROBE = 3'd4,
        S_RSHIFT  = 3'd5
    } slave_state_e;

    // Device-select field of a full bus address.
    function automatic logic [DEV_SEL_BITS-1:0] dev_sel_of(input logic [ADDR_BITS-1:0] a);
        return a[SEL_MSB:SEL_LSB];
    endfunction

endpackage

// File: rtl/bus_slave_if.sv
// -----------------------------------------------------------------------------
// bus_slave_if
// Signal bundle between the bus master and one bus slave.
//   master -> slave : valid, write_en, addr_rx, data_rx
//   slave -> master : data_tx, slave_valid, slave_ready, addr_miss
//
// Handshake: the master may raise valid for one cycle only while slave_ready
// is high; write_en is sampled together with valid. Address bits follow on
// addr_rx on the next 14 cycles (MSB first), the write datum on data_rx during
// the last 8 of those. For a read the slave answers with a one-cycle
// slave_valid strobe, then 8 data bits on data_tx (MSB first). valid seen
// while slave_ready is low is ignored.
// -----------------------------------------------------------------------------
interface bus_slave_if;

    logic valid;
    logic write_en;
    logic addr_rx;
    logic data_rx;
    logic data_tx;
    logic slave_valid;
    logic slave_ready;
    logic addr_miss;

    modport master (
        output valid, write_en, addr_rx, data_rx,
        input  data_tx, slave_valid, slave_ready, addr_miss
    );

    modport slave (
        input  valid, write_en, addr_rx, data_rx,
        output data_tx, slave_valid, slave_ready, addr_miss
    );

endinterface

// File: rtl/slave_mem.sv
// -----------------------------------------------------------------------------
// slave_mem
// Single-port synchronous RAM, DEPTH x DW, with a registered read port
// (one-cycle latency). Contents are not reset.
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable: mem[addr] <= wdata
//   re     in   read enable:  rdata <= mem[addr] (valid next cycle)
//   addr   in   AW-bit word address
//   wdata  in   DW-bit write data
//   rdata  out  DW-bit registered read data
// -----------------------------------------------------------------------------
module slave_mem #(
    parameter int DEPTH = 4096,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_slave.sv
// -----------------------------------------------------------------------------
// bus_slave
// Responder end of the bit-serial bus. Deserialises a 14-bit address and an
// 8-bit write datum, commits writes to a local byte memory and returns read
// data bit-serially after a one-cycle slave_valid strobe.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   bus        slave modport of bus_slave_if (valid, write_en, addr_rx,
//              data_rx in; data_tx, slave_valid, slave_ready, addr_miss out)
//   state_dbg  out  current FSM state (bus_pkg::slave_state_e encoding)
//
// Parameters:
//   DEV_ID     device select compared against address bits [13:12]
//   MEM_DEPTH  local bytes, addressed by the low address bits
//
// Build option BUS_SLAVE_ADDR_FILTER_EN:
//   defined   - frames whose device select differs from DEV_ID are dropped
//               and flagged with a one-cycle addr_miss pulse.
//   undefined - device select is ignored, every frame is accepted (memory
//               aliases across the select space) and addr_miss stays 0.
// -----------------------------------------------------------------------------
module bus_slave
    import bus_pkg::*;
#(
    parameter logic [DEV_SEL_BITS-1:0] DEV_ID    = 2'd0,
    parameter int                      MEM_DEPTH = 4096
) (
    input  logic           clock,
    input  logic           reset,
    bus_slave_if.slave     bus,
    output logic [2:0]     state_dbg
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);

    localparam logic [2:0] IDLE    = S_IDLE;
    localparam logic [2:0] ADDR    = S_ADDR;
    localparam logic [2:0] WCOMMIT = S_WCOMMIT;
    localparam logic [2:0] RFETCH  = S_RFETCH;
    localparam logic [2:0] RSTROBE = S_RSTROBE;
    localparam logic [2:0] RSHIFT  = S_RSHIFT;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [CNT_BITS-1:0]  bit_cnt;
    logic [ADDR_BITS-1:0] addr_sr;
    logic [ADDR_BITS-1:0] addr_next;
    logic [DATA_BITS-1:0] data_sr;
    logic [DATA_BITS-1:0] tx_sr;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 wr_frame;
    logic                 sel_miss;
    logic                 mem_we;
    logic                 mem_re;
    logic                 unused_bits;

    // Address register contents once the bit on addr_rx has been shifted in;
    // at the last address cycle this is the complete address, which lets the
    // device decode happen in the same cycle as the final shift.
    assign addr_next = {addr_sr[ADDR_BITS-2:0], bus.addr_rx};

`ifdef BUS_SLAVE_ADDR_FILTER_EN
    assign sel_miss    = (dev_sel_of(addr_next) != DEV_ID);
    assign unused_bits = addr_sr[ADDR_BITS-1];
`else
    assign sel_miss    = 1'b0;
    assign unused_bits = ^{addr_sr[ADDR_BITS-1], addr_next[SEL_MSB:SEL_LSB], DEV_ID};
`endif

    // ---------------------------------------------------------------- FSM --
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.valid) state_nxt = ADDR;
            ADDR:    if (bit_cnt == ADDR_LAST_CNT) state_nxt = wr_frame ? WCOMMIT : RFETCH;
            WCOMMIT: state_nxt = IDLE;
            // A missed read leaves here without fetching or strobing.
            RFETCH:  state_nxt = bus.addr_miss ? IDLE : RSTROBE;
            RSTROBE: state_nxt = RSHIFT;
            RSHIFT:  if (bit_cnt == TX_LAST_CNT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            addr_sr         <= '0;
            data_sr         <= '0;
            tx_sr           <= '0;
            wr_frame        <= 1'b0;
            bus.slave_valid <= 1'b0;
            bus.slave_ready <= 1'b1;
            bus.addr_miss   <= 1'b0;
        end else begin
            state           <= state_nxt;
            // Status outputs are registered copies of the next state so they
            // line up exactly with the state they describe.
            bus.slave_valid <= (state_nxt == RSTROBE);
            bus.slave_ready <= (state_nxt == IDLE);
            bus.addr_miss   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        wr_frame <= bus.write_en;
                        bit_cnt  <= '0;
                    end
                end

                ADDR: begin
                    addr_sr <= addr_next;
                    if (bit_cnt >= DATA_FIRST_CNT) begin
                        data_sr <= {data_sr[DATA_BITS-2:0], bus.data_rx};
                    end
                    if (bit_cnt == ADDR_LAST_CNT) begin
                        bit_cnt       <= '0;
                        // Flag lives for the one WCOMMIT/RFETCH cycle and
                        // suppresses the memory access there.
                        bus.addr_miss <= sel_miss;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                RSTROBE: begin
                    // RAM output register holds the byte fetched in RFETCH.
                    tx_sr <= mem_rdata;
                end

                RSHIFT: begin
                    // Zero fill leaves data_tx low once the byte is out.
                    tx_sr   <= {tx_sr[DATA_BITS-2:0], 1'b0};
                    bit_cnt <= (bit_cnt == TX_LAST_CNT) ? '0 : bit_cnt + 4'd1;
                end

                default: ;
            endcase
        end
    end

    assign bus.data_tx = tx_sr[DATA_BITS-1];
    assign state_dbg   = state;

    // ------------------------------------------------------------- memory --
    assign mem_we = (state == WCOMMIT) && !bus.addr_miss;
    assign mem_re = (state == RFETCH)  && !bus.addr_miss;

    slave_mem #(
        .DEPTH (MEM_DEPTH),
        .DW    (DATA_BITS)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_sr[MEM_AW-1:0]),
        .wdata (data_sr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_slave
// Directed bench for bus_slave. Frames are driven cycle by cycle on the
// falling edge; outputs are sampled on the same falling edge, so step k of a
// frame observes the values held during cycle T+k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_slave;
  import bus_pkg::*;

`ifdef BUS_SLAVE_ADDR_FILTER_EN
  localparam logic [1:0] TB_DEV_ID = 2'd1;
`else
  localparam logic [1:0] TB_DEV_ID = 2'd0;
`endif

  // ---------------------------------------------------- clock / reset --
  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  bus_slave_if bus ();

  bus_slave #(
    .DEV_ID    (TB_DEV_ID),
    .MEM_DEPTH (4096)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------- scoreboard --
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int miss_seen = 0;
  int miss_exp  = 0;

  always @(posedge clock) begin
    if (bus.addr_miss === 1'b1) miss_seen++;
  end

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] local_addr(input logic [11:0] off);
    return {TB_DEV_ID, off};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_tx"},     8'(bus.data_tx),     8'd0);
    check_eq({tag, "_slave_valid"}, 8'(bus.slave_valid), 8'd0);
    check_eq({tag, "_slave_ready"}, 8'(bus.slave_ready), 8'd1);
    check_eq({tag, "_addr_miss"},   8'(bus.addr_miss),   8'd0);
    check_eq({tag, "_state"},       8'(state_dbg),       8'd0);
  endtask

  // ----------------------------------------------------------- driver --
  // One frame, starting at the next falling edge. stray_step raises valid
  // again mid-frame; reset_step asserts reset at that step and aborts.
  task automatic run_frame(input string tag, input logic we, input logic [13:0] addr,
                           input logic [7:0] wdata, input bit exp_miss,
                           input int stray_step, input int reset_step);
    logic [7:0] rd;
    int last;
    last = (we || exp_miss) ? 15 : 24;
    rd = '0;
    if (exp_miss) miss_exp++;
    for (int k = 0; k <= last; k++) begin
      @(negedge clock);
      if (k == 0) begin
        check_eq({tag, "_ready_idle"},   8'(bus.slave_ready), 8'd1);
        check_eq({tag, "_data_tx_idle"}, 8'(bus.data_tx),     8'd0);
      end
      if (k == 1)  check_eq({tag, "_ready_busy"}, 8'(bus.slave_ready), 8'd0);
      if (k == 15) begin
        check_eq({tag, "_addr_miss"},  8'(bus.addr_miss),   8'(exp_miss));
        check_eq({tag, "_no_strobe"},  8'(bus.slave_valid), 8'd0);
      end
      if (k == 16) check_eq({tag, "_strobe"}, 8'(bus.slave_valid), 8'd1);
      if (k == 17) check_eq({tag, "_strobe_one"}, 8'(bus.slave_valid), 8'd0);
      if (k >= 17) rd = {rd[6:0], bus.data_tx};
      if (k == reset_step) begin
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.write_en = 1'b0;
        bus.addr_rx = 1'b0;
        bus.data_rx = 1'b0;
        #1;
        check_reset_outputs({tag, "_in_reset"});
        @(negedge clock);
        check_reset_outputs({tag, "_held_reset"});
        reset = 1'b0;
        return;
      end
      bus.valid    = (k == 0) || (k == stray_step);
      bus.write_en = (k == 0) ? we : 1'b0;
      bus.addr_rx  = (k >= 1 && k <= 14) ? addr[14-k] : 1'b0;
      bus.data_rx  = (k >= 7 && k <= 14) ? wdata[14-k] : 1'b0;
    end
    if (!we && !exp_miss) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_sb: read with empty expected queue", tag);
      end else begin
        check_eq({tag, "_rdata"}, rd, exp_q.pop_front());
      end
    end
  endtask

  task automatic write_frame(input string tag, input logic [13:0] addr, input logic [7:0] d,
                             input bit exp_miss, input int stray_step);
    run_frame(tag, 1'b1, addr, d, exp_miss, stray_step, -1);
  endtask

  task automatic read_frame(input string tag, input logic [13:0] addr, input logic [7:0] exp);
    exp_q.push_back(exp);
    run_frame(tag, 1'b0, addr, 8'd0, 1'b0, -1, -1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------------------------------------------------- stimulus --
  initial begin
    reset        = 1'b1;
    bus.valid    = 1'b0;
    bus.write_en = 1'b0;
    bus.addr_rx  = 1'b0;
    bus.data_rx  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("post_reset");

    // Write then read back; 8'hA5 serialises as 1,0,1,0,0,1,0,1.
    write_frame("wr_0123", local_addr(12'h123), 8'hA5, 1'b0, -1);
    idle_cycles(2);
    read_frame("rd_0123", local_addr(12'h123), 8'hA5);
    idle_cycles(2);

    // Back-to-back: read starts at T+16 of the write; stray valid at T+8.
    write_frame("b2b_wr", local_addr(12'hFFF), 8'h3C, 1'b0, 8);
    read_frame("b2b_rd", local_addr(12'hFFF), 8'h3C);
    idle_cycles(1);

    // Reset in the middle of an overwrite leaves the old byte in place.
    write_frame("pre_wr", local_addr(12'h010), 8'h5A, 1'b0, -1);
    run_frame("rst_wr", 1'b1, local_addr(12'h010), 8'hFF, 1'b0, -1, 10);
    idle_cycles(1);
    read_frame("rst_rd", local_addr(12'h010), 8'h5A);
    idle_cycles(1);

`ifdef BUS_SLAVE_ADDR_FILTER_EN
    // Write to select 0 is not for DEV_ID 1: dropped and flagged.
    write_frame("own_wr", 14'h1055, 8'h00, 1'b0, -1);
    write_frame("miss_wr", 14'h0055, 8'hAB, 1'b1, -1);
    read_frame("miss_rd", 14'h1055, 8'h00);
    run_frame("miss_rd_other", 1'b0, 14'h2055, 8'h00, 1'b1, -1, -1);
`else
    // Select bits ignored: offset 002 aliases across all selects.
    write_frame("alias_wr", 14'h3002, 8'h77, 1'b0, -1);
    read_frame("alias_rd", 14'h0002, 8'h77);
`endif
    idle_cycles(1);

    // Boundary offsets, checked for cross-corruption.
    write_frame("lo_wr", local_addr(12'h000), 8'h01, 1'b0, -1);
    write_frame("hi_wr", local_addr(12'hFFF), 8'h80, 1'b0, -1);
    read_frame("lo_rd", local_addr(12'h000), 8'h01);
    read_frame("hi_rd", local_addr(12'hFFF), 8'h80);
    read_frame("a5_still", local_addr(12'h123), 8'hA5);

    idle_cycles(2);
    check_eq("miss_pulse_count", 8'(miss_seen), 8'(miss_exp));
    check_eq("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
